staged_bank_register: RTL

- Multi-lane successor to the single-width data register: holds a LANES×8-bit value, written one byte at a time from the 8-bit CoCo data bus into a shadow copy.
- The shadow is applied atomically to the active output on an explicit commit, so the flash bank address never shows a half-updated value.
- A two-byte unlock key guards writes against stray bus cycles.
- Sits between the cartridge address decoder and the flash high-address / mode logic.

---
 rtl/staged_bank_register.sv | 128 ++++++++++++
 1 files changed

// File: rtl/staged_bank_register.sv
// staged_bank_register
//   Multi-lane bank register for the cartridge flash high-address and mode logic.
//   The value is LANES x 8 bits wide. Software writes it one byte at a time from
//   the 8-bit CoCo data bus into a shadow copy. A commit then copies the shadow
//   to the active output q in one edge, so the flash bank address never shows a
//   half-updated value. Writes are accepted only after a two-byte unlock key
//   (KEY0 then KEY1, written back-to-back to the control address).
//
//   Optional feature: define STAGED_BANK_AUTO_COMMIT_EN to make a write to the
//   top lane (LANES-1) also commit in the same edge. Without the macro, only a
//   control write with d[0] = 1 commits.
//
// Ports:
//   clock    in   bus clock (CoCo E); all state changes on its falling edge
//   reset    in   asynchronous, active-high reset
//   we       in   write strobe, sampled on the falling edge of clock
//   addr     in   [ADDR_W] 0..LANES-1 shadow lanes, LANES control, above unused
//   d        in   [8] write data
//   rd_data  out  [8] combinational read-back of the selected register
//   q        out  [8*LANES] active value, lane n = q[8n+7:8n]
//   locked   out  1 while the register is not unlocked
//   pending  out  1 while shadow differs from q
module staged_bank_register #(
    parameter int                 LANES  = 3,
    parameter int                 ADDR_W = 3,
    parameter logic [8*LANES-1:0] RESET  = '0,
    parameter logic [7:0]         KEY0   = 8'h55,
    parameter logic [7:0]         KEY1   = 8'hAA
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [7:0]           d,
    output logic [7:0]           rd_data,
    output logic [8*LANES-1:0]   q,
    output logic                 locked,
    output logic                 pending
);

    // The encoding is visible through the control read-back, so it is fixed.
    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_KEY_WAIT = 2'd1,
        ST_UNLOCKED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(LANES);
`ifdef STAGED_BANK_AUTO_COMMIT_EN
    localparam logic [ADDR_W-1:0] TOP_LANE  = ADDR_W'(LANES - 1);
`endif

    state_t             state_q, state_d;
    logic [8*LANES-1:0] shadow_q, shadow_d;
    logic [8*LANES-1:0] active_q, active_d;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_LOCKED;
            shadow_q <= RESET;
            active_q <= RESET;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;

        if (we) begin
            if (addr == CTRL_ADDR) begin
                case (state_q)
                    ST_LOCKED: begin
                        if (d == KEY0) state_d = ST_KEY_WAIT;
                    end
                    ST_KEY_WAIT: begin
                        // A repeated KEY0 keeps the sequence armed.
                        if (d == KEY1)      state_d = ST_UNLOCKED;
                        else if (d == KEY0) state_d = ST_KEY_WAIT;
                        else                state_d = ST_LOCKED;
                    end
                    ST_UNLOCKED: begin
                        // Commit uses the pre-edge shadow, so d = 8'h81
                        // commits and then locks in the same edge.
                        if (d[0]) active_d = shadow_q;
                        if (d[7]) state_d  = ST_LOCKED;
                    end
                    default: state_d = ST_LOCKED;
                endcase
            end else if (addr < CTRL_ADDR) begin
                if (state_q == ST_UNLOCKED) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (addr == ADDR_W'(i)) shadow_d[8*i +: 8] = d;
                    end
`ifdef STAGED_BANK_AUTO_COMMIT_EN
                    // The top lane write carries its own byte into q.
                    if (addr == TOP_LANE) active_d = shadow_d;
`endif
                end else if (state_q == ST_KEY_WAIT) begin
                    // The key must be two back-to-back control writes.
                    state_d = ST_LOCKED;
                end
            end else begin
                if (state_q == ST_KEY_WAIT) state_d = ST_LOCKED;
            end
        end
    end

    assign q       = active_q;
    assign locked  = (state_q != ST_UNLOCKED);
    assign pending = (shadow_q != active_q);

    always_comb begin
        rd_data = 8'h00;
        if (addr == CTRL_ADDR) begin
            rd_data = {locked, pending, 4'b0000, state_q};
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (addr == ADDR_W'(i)) rd_data = shadow_q[8*i +: 8];
            end
        end
    end

endmodule
